// File: rtl/alu.sv
// RV32I execute-stage ALU: combinational result plus a registered copy for pipelined consumers.
// Latency: out/zero same cycle, out_q/zero_q one clk edge; no flow control, a new operation every cycle.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_op,
  output logic [31:0] out,
  output logic        zero,
  output logic [31:0] out_q,
  output logic        zero_q
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_LTU = 4'b1011;
  localparam logic [3:0] OP_GE  = 4'b1100;
  localparam logic [3:0] OP_GEU = 4'b1101;

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = in2[4:0];
  assign lt_s  = $signed(in1) < $signed(in2);
  assign lt_u  = in1 < in2;

  // Compare results land in bit 0; reserved opcodes fall to the zero default.
  always_comb begin
    out = 32'h0000_0000;
    case (alu_op)
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_XOR:  out = in1 ^ in2;
      OP_OR:   out = in1 | in2;
      OP_AND:  out = in1 & in2;
      OP_SLL:  out = in1 << shamt;
      OP_SRL:  out = in1 >> shamt;
      OP_SRA:  out = 32'($signed(in1) >>> shamt);
      OP_EQ:   out = {31'b0, in1 == in2};
      OP_NE:   out = {31'b0, in1 != in2};
      OP_LT:   out = {31'b0, lt_s};
      OP_LTU:  out = {31'b0, lt_u};
      OP_GE:   out = {31'b0, ~lt_s};
      OP_GEU:  out = {31'b0, ~lt_u};
      default: out = 32'h0000_0000;
    endcase
  end

  assign zero = (out == 32'h0000_0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= 32'h0000_0000;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors from the opcode table plus random ops against an arithmetic model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in1 = 32'h0;
  logic [31:0] in2 = 32'h0;
  logic [3:0]  alu_op = 4'h0;
  logic [31:0] out;
  logic        zero;
  logic [31:0] out_q;
  logic        zero_q;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  alu dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .alu_op(alu_op),
    .out(out), .zero(zero), .out_q(out_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  // Reference built from integer arithmetic: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, p;
    longint          sa, sb, q;
    ua = a; ub = b;
    sa = int'(a); sb = int'(b);
    p  = 64'd1 << (b % 32);
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua + 64'h1_0000_0000 - ub);
      4'd2:  return a ^ b;
      4'd3:  return a | b;
      4'd4:  return a & b;
      4'd5:  return 32'(ua * p);
      4'd6:  return 32'(ua / p);
      4'd7: begin
        q = sa / longint'(p);
        if (sa < 0 && (sa % longint'(p)) != 0) q = q - 1;
        return 32'(q);
      end
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a != b) ? 32'd1 : 32'd0;
      4'd10: return (sa < sb)  ? 32'd1 : 32'd0;
      4'd11: return (ua < ub)  ? 32'd1 : 32'd0;
      4'd12: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd13: return (ua >= ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    in1 = 32'd4; in2 = 32'd6; alu_op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_q !== 32'h0 || zero_q !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d out_q=%h zero_q=%b expected 00000000/1", i, out_q, zero_q);
      end
    end
    // Release mid-cycle: nothing loads until the following rising edge.
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (out_q !== 32'h0 || zero_q !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_early out_q=%h zero_q=%b expected 00000000/1", out_q, zero_q);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 32'h0000_000a || zero_q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_load out_q=%h zero_q=%b expected 0000000a/0", out_q, zero_q);
    end
  endtask

  task automatic test_logic();
    vec_t v[5] = '{
      '{4'd0, 32'd4, 32'd6, 32'h0000_000a}, '{4'd1, 32'd4, 32'd6, 32'hffff_fffe},
      '{4'd2, 32'd4, 32'd6, 32'h0000_0002}, '{4'd3, 32'd4, 32'd6, 32'h0000_0006},
      '{4'd4, 32'd4, 32'd6, 32'h0000_0004}};
    foreach (v[i]) begin
      alu_op = v[i].op; in1 = v[i].a; in2 = v[i].b; #1;
      n_cmp++;
      if (out !== v[i].exp || zero !== 1'b0) begin
        n_err++;
        $display("FAIL logic op=%h out=%h zero=%b expected %h/0", v[i].op, out, zero, v[i].exp);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[7] = '{
      '{4'd5, 32'hf000_0004, 32'd4,  32'h0000_0040}, '{4'd6, 32'hf000_0004, 32'd4,  32'h0f00_0000},
      '{4'd7, 32'hf000_0004, 32'd4,  32'hff00_0000}, '{4'd5, 32'hf000_0004, 32'h24, 32'h0000_0040},
      '{4'd6, 32'hf000_0004, 32'h24, 32'h0f00_0000}, '{4'd7, 32'hf000_0004, 32'h24, 32'hff00_0000},
      '{4'd7, 32'h8000_0001, 32'hffff_ffe0, 32'h8000_0001}};
    foreach (v[i]) begin
      alu_op = v[i].op; in1 = v[i].a; in2 = v[i].b; #1;
      n_cmp++;
      if (out !== v[i].exp) begin
        n_err++;
        $display("FAIL shift op=%h in2=%h out=%h expected %h", v[i].op, v[i].b, out, v[i].exp);
      end
    end
  endtask

  task automatic test_compare();
    vec_t v[12] = '{
      '{4'd8,  32'd4, 32'd6, 32'd0}, '{4'd9,  32'd4, 32'd6, 32'd1},
      '{4'd8,  32'd7, 32'd7, 32'd1}, '{4'd9,  32'd7, 32'd7, 32'd0},
      '{4'd10, 32'hf000_0004, 32'd4, 32'd1}, '{4'd11, 32'hf000_0004, 32'd4, 32'd0},
      '{4'd12, 32'hf000_0004, 32'd4, 32'd0}, '{4'd13, 32'hf000_0004, 32'd4, 32'd1},
      '{4'd12, 32'hf000_0004, 32'hf000_0004, 32'd1}, '{4'd13, 32'hf000_0004, 32'hf000_0004, 32'd1},
      '{4'd10, 32'd9, 32'd9, 32'd0}, '{4'd11, 32'd9, 32'd9, 32'd0}};
    foreach (v[i]) begin
      alu_op = v[i].op; in1 = v[i].a; in2 = v[i].b; #1;
      n_cmp++;
      if (out !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        n_err++;
        $display("FAIL compare op=%h a=%h b=%h out=%h zero=%b expected %h", v[i].op, v[i].a, v[i].b, out, zero, v[i].exp);
      end
    end
  endtask

  task automatic test_edges();
    vec_t v[4] = '{
      '{4'd0,  32'hffff_ffff, 32'd1, 32'h0}, '{4'd15, 32'hdead_beef, 32'h1234_5678, 32'h0},
      '{4'd14, 32'hdead_beef, 32'hdead_beef, 32'h0}, '{4'd5, 32'hdead_beef, 32'h0000_0020, 32'hdead_beef}};
    foreach (v[i]) begin
      alu_op = v[i].op; in1 = v[i].a; in2 = v[i].b; #1;
      n_cmp++;
      if (out !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        n_err++;
        $display("FAIL edge op=%h out=%h zero=%b expected %h", v[i].op, out, zero, v[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      alu_op = 4'($urandom_range(0, 15));
      in1    = $urandom;
      case ($urandom_range(0, 3))
        0:       in2 = in1;
        1:       in2 = $urandom_range(0, 40);
        default: in2 = $urandom;
      endcase
      exp = model(alu_op, in1, in2);
      #1;
      n_cmp++;
      if (out !== exp || zero !== (exp == 32'd0)) begin
        n_err++;
        $display("FAIL random op=%h a=%h b=%h out=%h zero=%b expected %h", alu_op, in1, in2, out, zero, exp);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_q !== exp || zero_q !== (exp == 32'd0)) begin
        n_err++;
        $display("FAIL random_reg op=%h out_q=%h zero_q=%b expected %h", alu_op, out_q, zero_q, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_op = 4'd0; in1 = 32'd4; in2 = 32'd6;
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 32'h0000_000a || zero_q !== 1'b0) begin
      n_err++;
      $display("FAIL mid_load out_q=%h zero_q=%b expected 0000000a/0", out_q, zero_q);
    end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    n_cmp++;
    if (out_q !== 32'h0 || zero_q !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_async out_q=%h zero_q=%b expected 00000000/1", out_q, zero_q);
    end
    n_cmp++;
    if (out !== 32'h0000_000a) begin
      n_err++;
      $display("FAIL comb_ignores_reset out=%h expected 0000000a", out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 32'h0 || zero_q !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_hold out_q=%h zero_q=%b expected 00000000/1", out_q, zero_q);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_compare();
    test_edges();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
